// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI frame controller slice.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    SETUP = 3'd2,
    XFER  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } spi_frame_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam logic [15:0] SPI_MIN_PRESCALER = 16'd1;

  // A zero half-period would stall the prescaler, so it is raised to the minimum.
  function automatic logic [15:0] spi_clamp_prescaler(input logic [15:0] value);
    if (value < SPI_MIN_PRESCALER) begin
      return SPI_MIN_PRESCALER;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Front-end side of the SPI frame controller: start/config/data and status.
interface spi_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  start_i;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  cpol_i;
  logic                  cpha_i;
  logic [15:0]           prescaler_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] rx_data_o;

  // Register front-end: issues requests, observes status.
  modport master (
    output start_i, tx_data_i, cpol_i, cpha_i, prescaler_i,
    input  busy_o, done_o, rx_data_o
  );

  // Frame controller: consumes requests, reports status.
  modport slave (
    input  start_i, tx_data_i, cpol_i, cpha_i, prescaler_i,
    output busy_o, done_o, rx_data_o
  );

endinterface

// File: rtl/spi_shifter.sv
// Transmit/receive shift registers for one SPI frame. MOSI is a registered
// copy of the transmit MSB, updated only when the controller presents a bit,
// so CPHA=1 can hold the line until the first leading edge.
module spi_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  present_i,
  input  logic                  sample_i,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [DATA_WIDTH-1:0] rx_word_o
);

  logic [DATA_WIDTH-1:0] tx_sh_r;
  logic [DATA_WIDTH-1:0] rx_sh_r;
  logic                  mosi_r;

  // Load a new word, present the next MSB on MOSI, and shift sampled bits in at the LSB.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_sh_r <= {DATA_WIDTH{1'b0}};
      rx_sh_r <= {DATA_WIDTH{1'b0}};
      mosi_r  <= 1'b0;
    end else if (load_i) begin
      rx_sh_r <= {DATA_WIDTH{1'b0}};
      if (present_i) begin
        mosi_r  <= load_data_i[DATA_WIDTH-1];
        tx_sh_r <= {load_data_i[DATA_WIDTH-2:0], 1'b0};
      end else begin
        tx_sh_r <= load_data_i;
      end
    end else begin
      if (present_i) begin
        mosi_r  <= tx_sh_r[DATA_WIDTH-1];
        tx_sh_r <= {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
      end
      if (sample_i) begin
        rx_sh_r <= {rx_sh_r[DATA_WIDTH-2:0], miso_i};
      end
    end
  end

  assign mosi_o    = mosi_r;
  assign rx_word_o = rx_sh_r;

endmodule

// File: rtl/spi_frame_ctrl.sv
// Sequences one full-duplex SPI frame from external prescaler edge pulses.
// Every pulse in XFER is one SCLK edge; odd edges lead, even edges trail.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  spi_frame_ctrl_if.slave bus,
  output logic        prescaler_stb_o,
  output logic [15:0] prescaler_o,
  input  logic        high_pulse_i,
  input  logic        low_pulse_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        cs_o,
  input  logic        miso_i
);

  localparam int EDGES = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(EDGES) + 1;
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(EDGES);

  spi_frame_state_t      state_r;
  spi_mode_t             mode_r;
  logic                  arm_second_r;
  logic [CNT_W-1:0]      edge_cnt_r;
  logic                  cs_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  sclk_r;
  logic                  stb_r;
  logic [15:0]           presc_r;
  logic [DATA_WIDTH-1:0] rx_data_r;

  logic                  pulse_s;
  logic                  accept_s;
  logic [CNT_W-1:0]      edge_num_s;
  logic                  leading_s;
  logic                  last_edge_s;
  logic                  xfer_edge_s;
  logic                  load_s;
  logic                  present_s;
  logic                  sample_s;
  logic [DATA_WIDTH-1:0] rx_word_s;

  // Pulse type is irrelevant: the prescaler's clock parity is unknown to us.
  assign pulse_s     = high_pulse_i | low_pulse_i;
  assign accept_s    = (state_r == IDLE) && bus.start_i;
  assign edge_num_s  = edge_cnt_r + CNT_W'(1);
  assign leading_s   = edge_num_s[0];
  assign last_edge_s = (edge_num_s == LAST_EDGE);
  assign xfer_edge_s = (state_r == XFER) && pulse_s;

  // Decide per cycle whether the shifter loads, presents a bit, or samples MISO.
  always_comb begin
    load_s    = 1'b0;
    present_s = 1'b0;
    sample_s  = 1'b0;
    if (accept_s) begin
      load_s    = 1'b1;
      present_s = ~bus.cpha_i;
    end else if (xfer_edge_s) begin
      if (mode_r.cpha) begin
        present_s = leading_s;
        sample_s  = ~leading_s;
      end else begin
        sample_s  = leading_s;
        present_s = ~leading_s & ~last_edge_s;
      end
    end else begin
      load_s    = 1'b0;
      present_s = 1'b0;
      sample_s  = 1'b0;
    end
  end

  spi_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_s),
    .load_data_i (bus.tx_data_i),
    .present_i   (present_s),
    .sample_i    (sample_s),
    .miso_i      (miso_i),
    .mosi_o      (mosi_o),
    .rx_word_o   (rx_word_s)
  );

  // Frame FSM with edge counter, ARM blanking and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      mode_r       <= spi_mode_t'(2'b00);
      arm_second_r <= 1'b0;
      edge_cnt_r   <= {CNT_W{1'b0}};
      cs_r         <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      sclk_r       <= 1'b0;
      stb_r        <= 1'b0;
      presc_r      <= 16'd0;
      rx_data_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      stb_r  <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          sclk_r <= bus.cpol_i;
          if (bus.start_i) begin
            mode_r       <= spi_mode_t'({bus.cpol_i, bus.cpha_i});
            presc_r      <= spi_clamp_prescaler(bus.prescaler_i);
            stb_r        <= 1'b1;
            cs_r         <= 1'b0;
            busy_r       <= 1'b1;
            arm_second_r <= 1'b0;
            edge_cnt_r   <= {CNT_W{1'b0}};
            state_r      <= ARM;
          end
        end
        ARM: begin
          // Pulses are deliberately ignored: they belong to the previous count.
          if (arm_second_r) begin
            state_r <= SETUP;
          end else begin
            arm_second_r <= 1'b1;
          end
        end
        SETUP: begin
          if (pulse_s) begin
            state_r <= XFER;
          end
        end
        XFER: begin
          if (pulse_s) begin
            sclk_r     <= ~sclk_r;
            edge_cnt_r <= edge_num_s;
            if (last_edge_s) begin
              state_r <= HOLD;
            end
          end
        end
        HOLD: begin
          if (pulse_s) begin
            sclk_r    <= mode_r.cpol;
            cs_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            rx_data_r <= rx_word_s;
            state_r   <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          cs_r    <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign cs_o            = cs_r;
  assign sclk_o          = sclk_r;
  assign prescaler_stb_o = stb_r;
  assign prescaler_o     = presc_r;
  assign bus.busy_o      = busy_r;
  assign bus.done_o      = done_r;
  assign bus.rx_data_o   = rx_data_r;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl with a prescaler pulse model and an SPI slave model.
module tb_spi_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic [15:0] presc_out;
  logic        high_pulse;
  logic        low_pulse;
  logic        sclk;
  logic        mosi;
  logic        cs;
  logic        miso;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_start = 0;

  spi_frame_ctrl_if #(.DATA_WIDTH(8)) bus ();

  spi_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus),
    .prescaler_stb_o (stb),
    .prescaler_o     (presc_out),
    .high_pulse_i    (high_pulse),
    .low_pulse_i     (low_pulse),
    .sclk_o          (sclk),
    .mosi_o          (mosi),
    .cs_o            (cs),
    .miso_i          (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Prescaler model: first pulse P+1 cycles after the strobe cycle, then every P.
  int          pcnt = 0;
  logic [15:0] pval = 16'd1;
  logic        pphase = 1'b0;
  logic        inject = 1'b0;
  always @(posedge clk) begin
    if (stb) begin
      pcnt <= int'(presc_out) + 1;
      pval <= presc_out;
    end else if (pcnt == 1) begin
      pcnt   <= int'(pval);
      pphase <= ~pphase;
    end else if (pcnt > 1) begin
      pcnt <= pcnt - 1;
    end
  end
  assign high_pulse = ((pcnt == 1) && pphase) || inject;
  assign low_pulse  = (pcnt == 1) && !pphase;

  // Slave model: shifts slave_word out MSB first, changing on trailing (CPHA=0) or leading (CPHA=1) edges.
  logic       loopback = 1'b1;
  logic       slave_cpha = 1'b0;
  logic [7:0] slave_word = 8'hC3;
  logic       sclk_d = 1'b0;
  int         edges_seen = 0;
  int         eff;
  int         idx;
  logic       slave_bit;
  always @(posedge clk) begin
    sclk_d <= sclk;
    if (cs) edges_seen <= 0;
    else if (sclk != sclk_d) edges_seen <= edges_seen + 1;
  end
  always_comb begin
    eff = edges_seen + ((!cs && (sclk != sclk_d)) ? 1 : 0);
    idx = slave_cpha ? ((eff + 1) / 2 - 1) : (eff / 2);
    if (idx < 0) idx = 0;
    if (idx > 7) idx = 7;
    slave_bit = slave_word[7 - idx];
  end
  assign miso = loopback ? mosi : slave_bit;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a request in the current cycle and check the first ARM cycle.
  task automatic start_frame(input string tag, input logic [7:0] tx, input logic cpha,
                             input logic [15:0] presc, input logic [15:0] exp_p, input bit hold);
    logic [7:0] txv;
    txv = tx;
    bus.tx_data_i   = tx;
    bus.cpha_i      = cpha;
    bus.prescaler_i = presc;
    bus.start_i     = 1'b1;
    t_start = cyc;
    tick();
    if (!hold) bus.start_i = 1'b0;
    check({tag, "_stb"},  32'(stb), 32'd1);
    check({tag, "_cs"},   32'(cs), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
    check({tag, "_presc"}, 32'(presc_out), 32'(exp_p));
    if (!cpha) check({tag, "_mosi_msb"}, 32'(mosi), 32'(txv[7]));
  endtask

  // Follow the frame to done_o (bounded) and check latency, data and pin behaviour.
  task automatic wait_done(input string tag, input int exp_lat, input logic [7:0] exp_rx, input int chg_at);
    bit   got;
    int   rises;
    int   cs_hi;
    logic sclk_prev;
    got = 1'b0; rises = 0; cs_hi = 0; sclk_prev = sclk;
    for (int i = 0; i < 400; i++) begin
      if (sclk && !sclk_prev) rises++;
      sclk_prev = sclk;
      if (bus.done_o) begin
        got = 1'b1;
        break;
      end
      if (cs) cs_hi++;
      if (chg_at > 0 && cyc == t_start + chg_at) begin
        bus.tx_data_i   = 8'h96;
        bus.cpha_i      = 1'b1;
        bus.prescaler_i = 16'd3;
      end
      tick();
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc - t_start), 32'(exp_lat));
    check({tag, "_rx"}, 32'(bus.rx_data_o), 32'(exp_rx));
    check({tag, "_busy_at_done"}, 32'(bus.busy_o), 32'd0);
    check({tag, "_cs_at_done"}, 32'(cs), 32'd1);
    check({tag, "_sclk_rises"}, 32'(rises), 32'd8);
    check({tag, "_cs_high_in_frame"}, 32'(cs_hi), 32'd0);
  endtask

  initial begin
    int dones;
    logic mode_cpol;
    logic mode_cpha;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.tx_data_i = 8'h00;
    bus.cpol_i = 1'b0;
    bus.cpha_i = 1'b0;
    bus.prescaler_i = 16'd1;
    tick(); tick(); tick();

    // Reset state
    check("rst_cs",    32'(cs), 32'd1);
    check("rst_busy",  32'(bus.busy_o), 32'd0);
    check("rst_done",  32'(bus.done_o), 32'd0);
    check("rst_sclk",  32'(sclk), 32'd0);
    check("rst_mosi",  32'(mosi), 32'd0);
    check("rst_stb",   32'(stb), 32'd0);
    check("rst_presc", 32'(presc_out), 32'd0);
    check("rst_rx",    32'(bus.rx_data_o), 32'd0);
    rst = 1'b0;
    tick(); tick();

    // Mode 0, P=2, 0xA5 looped back
    loopback = 1'b1;
    start_frame("m0", 8'hA5, 1'b0, 16'd2, 16'd2, 1'b0);
    tick();
    check("m0_stb_second_arm", 32'(stb), 32'd0);
    wait_done("m0", 39, 8'hA5, 0);
    tick();
    check("m0_done_single", 32'(bus.done_o), 32'd0);
    check("m0_sclk_idle_after", 32'(sclk), 32'd0);

    // Modes 1..3, P=1, slave returns 0xC3
    loopback = 1'b0;
    slave_word = 8'hC3;
    for (int m = 1; m < 4; m++) begin
      mode_cpol = (m >= 2);
      mode_cpha = (m == 1) || (m == 3);
      bus.cpol_i = mode_cpol;
      slave_cpha = mode_cpha;
      tick(); tick();
      check($sformatf("mode%0d_sclk_idle_before", m), 32'(sclk), 32'(mode_cpol));
      start_frame($sformatf("mode%0d", m), 8'h3C, mode_cpha, 16'd1, 16'd1, 1'b0);
      wait_done($sformatf("mode%0d", m), 21, 8'hC3, 0);
      tick();
      check($sformatf("mode%0d_sclk_idle_after", m), 32'(sclk), 32'(mode_cpol));
    end
    bus.cpol_i = 1'b0;
    loopback = 1'b1;
    tick(); tick();

    // prescaler_i = 0 behaves as P=1
    start_frame("p0", 8'h55, 1'b0, 16'd0, 16'd1, 1'b0);
    wait_done("p0", 21, 8'h55, 0);
    tick(); tick();

    // start_i held high; mid-frame input changes ignored
    start_frame("held1", 8'h5A, 1'b0, 16'd2, 16'd2, 1'b1);
    wait_done("held1", 39, 8'h5A, 5);
    tick();
    check("held_gap_done", 32'(bus.done_o), 32'd0);
    check("held_gap_busy", 32'(bus.busy_o), 32'd0);
    check("held_gap_cs", 32'(cs), 32'd1);
    t_start = cyc;
    tick();
    bus.start_i = 1'b0;
    check("held2_stb", 32'(stb), 32'd1);
    check("held2_cs", 32'(cs), 32'd0);
    check("held2_presc", 32'(presc_out), 32'd3);
    wait_done("held2", 57, 8'h96, 0);
    bus.cpha_i = 1'b0;
    tick(); tick();

    // Reset asserted mid-XFER
    start_frame("rstx", 8'hF0, 1'b0, 16'd2, 16'd2, 1'b0);
    while (cyc < t_start + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstx_cs", 32'(cs), 32'd1);
    check("rstx_sclk", 32'(sclk), 32'd0);
    check("rstx_busy", 32'(bus.busy_o), 32'd0);
    check("rstx_done", 32'(bus.done_o), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o) dones++;
      tick();
    end
    check("rstx_no_done", 32'(dones), 32'd0);
    start_frame("after_rst", 8'h81, 1'b0, 16'd2, 16'd2, 1'b0);
    wait_done("after_rst", 39, 8'h81, 0);
    tick(); tick();

    // Stale pulses injected during both ARM cycles
    start_frame("stale", 8'h69, 1'b0, 16'd4, 16'd4, 1'b0);
    inject = 1'b1;
    tick();
    check("stale_arm2_cs", 32'(cs), 32'd0);
    tick();
    inject = 1'b0;
    wait_done("stale", 75, 8'h69, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
